// File: rtl/seq_multdiv.sv
// Iterative multiply/divide unit with HI/LO result registers.
// One product/quotient bit per cycle; signs are removed on accept and restored on the final write.
module seq_multdiv #(
  parameter int N  = 18,
  parameter int CW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic [2:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         dz_o,
  output logic [N-1:0] hi_o,
  output logic [N-1:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*N-1:0]  w_q, w_step;
  logic [N-1:0]    mb_q;
  logic            div_q, sneg_q, rneg_q, bz_q;
  logic [N-1:0]    hi_q, lo_q;
  logic            dz_q;

  logic            accept, is_md, a_neg, b_neg, last;
  logic [N-1:0]    mag_a, mag_b;
  logic [N:0]      mul_sum, div_r, div_diff;
  logic [2*N-1:0]  prod;
  logic [N-1:0]    quo, rem, res_hi, res_lo;

  assign accept = start_i && (state_q != S_RUN);
  assign is_md  = ~op_i[2];
  assign a_neg  = is_md & op_i[0] & a_i[N-1];
  assign b_neg  = is_md & op_i[0] & b_i[N-1];
  assign mag_a  = a_neg ? -a_i : a_i;
  assign mag_b  = b_neg ? -b_i : b_i;
  assign last   = (state_q == S_RUN) && (cnt_q == '0);

  // Work register: multiply keeps {partial product, remaining multiplier bits};
  // divide keeps {partial remainder, remaining dividend bits / quotient bits}.
  always_comb begin
    mul_sum  = {1'b0, w_q[2*N-1:N]} + {1'b0, (w_q[0] ? mb_q : {N{1'b0}})};
    div_r    = {w_q[2*N-1:N], w_q[N-1]};
    div_diff = div_r - {1'b0, mb_q};
    if (div_q) begin
      if (div_diff[N]) w_step = {div_r[N-1:0], w_q[N-2:0], 1'b0};
      else             w_step = {div_diff[N-1:0], w_q[N-2:0], 1'b1};
    end else begin
      w_step = {mul_sum, w_q[N-1:1]};
    end
  end

  // Divide by zero naturally leaves |a| as the remainder, so restoring the
  // dividend sign reproduces the raw operand in HI.
  always_comb begin
    prod   = sneg_q ? -w_step : w_step;
    quo    = w_step[N-1:0];
    rem    = w_step[2*N-1:N];
    res_lo = prod[N-1:0];
    res_hi = prod[2*N-1:N];
    if (div_q) begin
      res_lo = bz_q ? {N{1'b1}} : (sneg_q ? -quo : quo);
      res_hi = rneg_q ? -rem : rem;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      S_IDLE, S_FIN: begin
        done_o  = (state_q == S_FIN);
        state_d = S_IDLE;
        if (start_i && is_md) begin
          state_d = S_RUN;
          cnt_d   = CW'(N-1);
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        if (cnt_q == '0) state_d = S_FIN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q    <= '0;
      mb_q   <= '0;
      div_q  <= 1'b0;
      sneg_q <= 1'b0;
      rneg_q <= 1'b0;
      bz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      dz_q   <= 1'b0;
    end else if (accept && is_md) begin
      w_q    <= {{N{1'b0}}, mag_a};
      mb_q   <= mag_b;
      div_q  <= op_i[1];
      sneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      bz_q   <= (b_i == '0);
      dz_q   <= 1'b0;
    end else if (accept && op_i == 3'b100) begin
      hi_q <= a_i;
      dz_q <= 1'b0;
    end else if (accept && op_i == 3'b101) begin
      lo_q <= a_i;
      dz_q <= 1'b0;
    end else if (state_q == S_RUN) begin
      w_q <= w_step;
      if (last) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
        dz_q <= div_q & bz_q;
      end
    end
  end

  assign dz_o = dz_q;
  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: tb/tb_seq_multdiv.sv
// Scoreboarded bench for seq_multdiv: arithmetic reference model feeds a queue,
// a monitor pops an entry on every done pulse.
module tb_seq_multdiv;
  localparam int N  = 18;
  localparam int CW = 5;
  localparam longint MASK = (longint'(1) << N) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [2:0]   op_i;
  logic [N-1:0] a_i, b_i;
  logic         busy_o, done_o, dz_o;
  logic [N-1:0] hi_o, lo_o;

  seq_multdiv #(.N(N), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .dz_o(dz_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dz;
    int           t0;
    string        name;
  } exp_t;

  exp_t         sbq[$];
  int           checks = 0;
  int           errors = 0;
  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;
  logic         m_dz = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint sx(input logic [N-1:0] v);
    return v[N-1] ? (longint'(v) - (longint'(1) << N)) : longint'(v);
  endfunction

  function automatic exp_t model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t   e;
    longint p, q, r;
    e.dz = 1'b0;
    e.t0 = 0;
    e.name = $sformatf("op%0d a=%0h b=%0h", op, a, b);
    if (op[1] == 1'b0) begin
      p = (op[0]) ? sx(a) * sx(b) : longint'(a) * longint'(b);
      e.hi = N'((p >> N) & MASK);
      e.lo = N'(p & MASK);
    end else if (b == '0) begin
      e.hi = a;
      e.lo = '1;
      e.dz = 1'b1;
    end else begin
      if (op[0]) begin
        q = sx(a) / sx(b);
        r = sx(a) % sx(b);
      end else begin
        q = longint'(a) / longint'(b);
        r = longint'(a) % longint'(b);
      end
      e.hi = N'(r & MASK);
      e.lo = N'(q & MASK);
    end
    return e;
  endfunction

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    start_i = 1'b1;
    op_i = op;
    a_i = a;
    b_i = b;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    a_i = N'($urandom);
    b_i = N'($urandom);
    if (op[2] == 1'b0) begin
      e = model(op, a, b);
      e.t0 = cyc;
      sbq.push_back(e);
    end else if (op == 3'b100) begin
      m_hi = a;
      m_dz = 1'b0;
    end else if (op == 3'b101) begin
      m_lo = a;
      m_dz = 1'b0;
    end
  endtask

  task automatic mt_check(input string name);
    chk({name, " hi"}, 64'(hi_o), 64'(m_hi));
    chk({name, " lo"}, 64'(lo_o), 64'(m_lo));
    chk({name, " dz"}, 64'(dz_o), 64'(m_dz));
    chk({name, " no_done"}, 64'(done_o), 64'(0));
    chk({name, " no_busy"}, 64'(busy_o), 64'(0));
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_o && n < N + 10);
    chk({name, " done_seen"}, 64'(done_o), 64'(1));
  endtask

  task automatic check_zero(input string name);
    chk({name, " hi"}, 64'(hi_o), 64'(0));
    chk({name, " lo"}, 64'(lo_o), 64'(0));
    chk({name, " busy"}, 64'(busy_o), 64'(0));
    chk({name, " done"}, 64'(done_o), 64'(0));
    chk({name, " dz"}, 64'(dz_o), 64'(0));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && done_o === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
      end else begin
        e = sbq.pop_front();
        chk({e.name, " hi"}, 64'(hi_o), 64'(e.hi));
        chk({e.name, " lo"}, 64'(lo_o), 64'(e.lo));
        chk({e.name, " dz"}, 64'(dz_o), 64'(e.dz));
        chk({e.name, " latency"}, 64'(cyc - e.t0), 64'(N));
        chk({e.name, " busy_at_done"}, 64'(busy_o), 64'(0));
        m_hi = e.hi;
        m_lo = e.lo;
        m_dz = e.dz;
      end
    end else if (rst_n === 1'b1 && busy_o === 1'b1) begin
      chk("hold_hi_during_run", 64'(hi_o), 64'(m_hi));
      chk("hold_lo_during_run", 64'(lo_o), 64'(m_lo));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   op;
    logic [N-1:0] ra, rb;
    rst_n = 1'b0;
    start_i = 1'b0;
    op_i = '0;
    a_i = '0;
    b_i = '0;
    #2;
    check_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(3'b100, 18'h00155, 18'h0);
    mt_check("mthi");
    @(negedge clk);
    issue(3'b101, 18'h002AA, 18'h0);
    mt_check("mtlo");
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("idle_reset");
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'b000, 18'h3FFFF, 18'h3FFFF);
    wait_done("multu_max");
    @(negedge clk);
    chk("done_one_cycle", 64'(done_o), 64'(0));

    issue(3'b001, 18'h3FFFD, 18'h00005);
    wait_done("mult_neg");
    chk("mult_neg hi_const", 64'(hi_o), 64'(18'h3FFFF));
    chk("mult_neg lo_const", 64'(lo_o), 64'(18'h3FFF1));
    issue(3'b010, 18'd100, 18'd7);
    wait_done("divu_b2b");
    chk("divu_b2b lo_const", 64'(lo_o), 64'(14));
    chk("divu_b2b hi_const", 64'(hi_o), 64'(2));

    @(negedge clk);
    issue(3'b011, 18'h3FFF9, 18'h00002);
    wait_done("div_neg");
    @(negedge clk);
    issue(3'b011, 18'h20000, 18'h3FFFF);
    wait_done("div_wrap");
    chk("div_wrap lo_const", 64'(lo_o), 64'(18'h20000));

    @(negedge clk);
    issue(3'b010, 18'h12345, 18'h0);
    wait_done("divu_zero");
    @(negedge clk);
    chk("dz_held", 64'(dz_o), 64'(1));
    issue(3'b101, 18'h00042, 18'h0);
    mt_check("mtlo_after_dz");

    @(negedge clk);
    issue(3'b110, 18'h3ABCD, 18'h11111);
    mt_check("reserved_op");

    @(negedge clk);
    issue(3'b000, 18'd7, 18'd9);
    repeat (3) @(negedge clk);
    start_i = 1'b1;
    op_i = 3'b100;
    a_i = 18'h01555;
    @(posedge clk);
    #1 start_i = 1'b0;
    chk("start_ignored busy", 64'(busy_o), 64'(1));
    wait_done("multu_7x9_ignored");
    chk("multu_7x9 lo_const", 64'(lo_o), 64'(63));

    @(negedge clk);
    issue(3'b000, 18'd7, 18'd9);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("run_reset");
    sbq.delete();
    m_hi = '0;
    m_lo = '0;
    m_dz = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b000, 18'd7, 18'd9);
    wait_done("multu_after_reset");

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) != 0) @(negedge clk);
      op = 3'($urandom_range(0, 5));
      ra = N'($urandom);
      rb = N'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: ra = 18'h20000;
        3: rb = N'($urandom_range(1, 5));
        default: ;
      endcase
      issue(op, ra, rb);
      if (op[2]) mt_check("rand_mt");
      else wait_done("rand_md");
    end

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
